// File: rtl/pipe_hazard_ctrl.sv
// Front-end sequencing controller: PC / pipe-register enables and flushes for
// load-use stalls, multi-cycle vector ops in EX and taken branches, plus a stall counter.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int VLAT   = 4,
    parameter int CNT_W  = 3,
    parameter int PERF_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_is_vec,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              branch_taken_ex,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              ex_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        VBUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]  VCNT_INIT = CNT_W'(VLAT - 1);
    localparam logic [PERF_W-1:0] STALL_MAX = '1;
    localparam logic              VEC_MULTI = (VLAT > 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  vcnt_q, vcnt_d;
    logic              rst_q, rst_d;
    logic [PERF_W-1:0] stall_q, stall_d;
    logic              lu;

    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign lu = ex_mem_read && id_valid && (ex_rd != '0) &&
                ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

    always_comb begin
        state_d      = state_q;
        vcnt_d       = vcnt_q;
        rst_d        = 1'b1;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        ex_busy      = 1'b0;

        if (!rst_q) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (state_q == VBUSY) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            ex_busy      = 1'b1;
            vcnt_d       = vcnt_q - 1'b1;
            if (vcnt_q == 1) begin
                state_d = IDLE;
            end
        end else if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (id_valid && id_is_vec && VEC_MULTI) begin
            // The op enters EX on this edge; hold everything behind it for VLAT-1 cycles.
            state_d = VBUSY;
            vcnt_d  = VCNT_INIT;
        end

        stall_d = stall_q;
        if (rst_q && !pc_en && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            vcnt_q  <= '0;
            rst_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            vcnt_q  <= vcnt_d;
            rst_q   <= rst_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (VLAT=4, PERF_W=4 so saturation is reachable).
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int PERF_W = 4;

    // Control vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, ex_busy
    localparam logic [6:0] FORCED_CTL = 7'b0010110;
    localparam logic [6:0] NORMAL_CTL = 7'b1101000;
    localparam logic [6:0] LU_CTL     = 7'b0001100;
    localparam logic [6:0] BRANCH_CTL = 7'b1111100;
    localparam logic [6:0] VBUSY_CTL  = 7'b0000011;

    logic              CLK;
    logic              RST;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              id_is_vec;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              branch_taken_ex;
    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_en;
    logic              id_ex_flush;
    logic              ex_mem_flush;
    logic              ex_busy;
    logic [PERF_W-1:0] stall_cycles;
    logic [6:0]        ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, ex_busy};

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW),
        .VLAT  (4),
        .CNT_W (3),
        .PERF_W(PERF_W)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_is_vec      (id_is_vec),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .branch_taken_ex(branch_taken_ex),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_en       (id_ex_en),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_flush   (ex_mem_flush),
        .ex_busy        (ex_busy),
        .stall_cycles   (stall_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid        = 1'b0;
        id_rs1          = '0;
        id_rs2          = '0;
        id_rs1_used     = 1'b0;
        id_rs2_used     = 1'b0;
        id_is_vec       = 1'b0;
        ex_rd           = '0;
        ex_mem_read     = 1'b0;
        branch_taken_ex = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        id_valid  = 1'b1;
        id_is_vec = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ctl !== VBUSY_CTL) begin errors++; $display("[TB] FAIL reset_pre_vbusy: got %b expected %b", ctl, VBUSY_CTL); end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (ctl !== FORCED_CTL) begin errors++; $display("[TB] FAIL reset_async_ctl: got %b expected %b", ctl, FORCED_CTL); end
        checks++;
        if (stall_cycles !== 4'd0) begin errors++; $display("[TB] FAIL reset_async_stall: got %0d expected 0", stall_cycles); end
        tick();
        RST = 1'b1;
        #2;
        checks++;
        if (ctl !== FORCED_CTL) begin errors++; $display("[TB] FAIL reset_release_ctl: got %b expected %b", ctl, FORCED_CTL); end
        tick();
        checks++;
        if (ctl !== NORMAL_CTL) begin errors++; $display("[TB] FAIL reset_after_ctl: got %b expected %b", ctl, NORMAL_CTL); end
        checks++;
        if (stall_cycles !== 4'd0) begin errors++; $display("[TB] FAIL reset_after_stall: got %0d expected 0", stall_cycles); end
    endtask

    task automatic test_load_use();
        do_reset();
        id_valid    = 1'b1;
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        id_rs1      = 5'd3;
        id_rs1_used = 1'b1;
        id_rs2      = 5'd5;
        id_rs2_used = 1'b1;
        #1;
        checks++;
        if (ctl !== LU_CTL) begin errors++; $display("[TB] FAIL lu_rs2_ctl: got %b expected %b", ctl, LU_CTL); end
        tick();
        ex_mem_read = 1'b0;
        #1;
        checks++;
        if (ctl !== NORMAL_CTL) begin errors++; $display("[TB] FAIL lu_rs2_release: got %b expected %b", ctl, NORMAL_CTL); end
        checks++;
        if (stall_cycles !== 4'd1) begin errors++; $display("[TB] FAIL lu_rs2_stall: got %0d expected 1", stall_cycles); end

        ex_mem_read = 1'b1;
        ex_rd       = 5'd0;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        #1;
        checks++;
        if (ctl !== NORMAL_CTL) begin errors++; $display("[TB] FAIL lu_r0_ctl: got %b expected %b", ctl, NORMAL_CTL); end
        tick();
        checks++;
        if (stall_cycles !== 4'd1) begin errors++; $display("[TB] FAIL lu_r0_stall: got %0d expected 1", stall_cycles); end

        ex_rd       = 5'd7;
        id_rs1      = 5'd7;
        id_rs2      = 5'd2;
        #1;
        checks++;
        if (ctl !== LU_CTL) begin errors++; $display("[TB] FAIL lu_rs1_ctl: got %b expected %b", ctl, LU_CTL); end
        id_rs1_used = 1'b0;
        #1;
        checks++;
        if (ctl !== NORMAL_CTL) begin errors++; $display("[TB] FAIL lu_rs1_unused: got %b expected %b", ctl, NORMAL_CTL); end
        id_rs1_used = 1'b1;
        id_valid    = 1'b0;
        #1;
        checks++;
        if (ctl !== NORMAL_CTL) begin errors++; $display("[TB] FAIL lu_bubble: got %b expected %b", ctl, NORMAL_CTL); end
        idle_inputs();
    endtask

    task automatic test_vector();
        do_reset();
        id_valid  = 1'b1;
        id_is_vec = 1'b1;
        #1;
        checks++;
        if (ctl !== NORMAL_CTL) begin errors++; $display("[TB] FAIL vec_issue_ctl: got %b expected %b", ctl, NORMAL_CTL); end
        tick();
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++;
            if (ctl !== VBUSY_CTL) begin errors++; $display("[TB] FAIL vec_busy_%0d: got %b expected %b", k, ctl, VBUSY_CTL); end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (ctl !== NORMAL_CTL) begin errors++; $display("[TB] FAIL vec_exit_ctl: got %b expected %b", ctl, NORMAL_CTL); end
        checks++;
        if (stall_cycles !== 4'd3) begin errors++; $display("[TB] FAIL vec_stall: got %0d expected 3", stall_cycles); end
    endtask

    task automatic test_branch_priority();
        do_reset();
        branch_taken_ex = 1'b1;
        id_valid        = 1'b1;
        id_is_vec       = 1'b1;
        ex_mem_read     = 1'b1;
        ex_rd           = 5'd9;
        id_rs1          = 5'd9;
        id_rs1_used     = 1'b1;
        #1;
        checks++;
        if (ctl !== BRANCH_CTL) begin errors++; $display("[TB] FAIL br_lu_ctl: got %b expected %b", ctl, BRANCH_CTL); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ctl !== NORMAL_CTL) begin errors++; $display("[TB] FAIL br_no_vbusy: got %b expected %b", ctl, NORMAL_CTL); end
        checks++;
        if (stall_cycles !== 4'd0) begin errors++; $display("[TB] FAIL br_stall: got %0d expected 0", stall_cycles); end
    endtask

    task automatic test_branch_during_vbusy();
        do_reset();
        id_valid  = 1'b1;
        id_is_vec = 1'b1;
        tick();
        idle_inputs();
        tick();
        branch_taken_ex = 1'b1;
        #1;
        checks++;
        if (ctl !== VBUSY_CTL) begin errors++; $display("[TB] FAIL vbusy_branch_ctl: got %b expected %b", ctl, VBUSY_CTL); end
        tick();
        branch_taken_ex = 1'b0;
        #1;
        checks++;
        if (ctl !== VBUSY_CTL) begin errors++; $display("[TB] FAIL vbusy_branch_after: got %b expected %b", ctl, VBUSY_CTL); end
        tick();
        checks++;
        if (ctl !== NORMAL_CTL) begin errors++; $display("[TB] FAIL vbusy_branch_exit: got %b expected %b", ctl, NORMAL_CTL); end
        checks++;
        if (stall_cycles !== 4'd3) begin errors++; $display("[TB] FAIL vbusy_branch_stall: got %0d expected 3", stall_cycles); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        id_valid    = 1'b1;
        id_is_vec   = 1'b1;
        id_rs2      = 5'd4;
        id_rs2_used = 1'b1;
        ex_rd       = 5'd4;
        ex_mem_read = 1'b1;
        #1;
        checks++;
        if (ctl !== LU_CTL) begin errors++; $display("[TB] FAIL b2b_lu_ctl: got %b expected %b", ctl, LU_CTL); end
        tick();
        ex_mem_read = 1'b0;
        ex_rd       = 5'd0;
        #1;
        checks++;
        if (ctl !== NORMAL_CTL) begin errors++; $display("[TB] FAIL b2b_issue_ctl: got %b expected %b", ctl, NORMAL_CTL); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ctl !== VBUSY_CTL) begin errors++; $display("[TB] FAIL b2b_vbusy_ctl: got %b expected %b", ctl, VBUSY_CTL); end
        tick();
        tick();
        tick();
        checks++;
        if (ctl !== NORMAL_CTL) begin errors++; $display("[TB] FAIL b2b_exit_ctl: got %b expected %b", ctl, NORMAL_CTL); end
        checks++;
        if (stall_cycles !== 4'd4) begin errors++; $display("[TB] FAIL b2b_stall: got %0d expected 4", stall_cycles); end
    endtask

    task automatic test_saturation();
        do_reset();
        id_valid    = 1'b1;
        ex_mem_read = 1'b1;
        ex_rd       = 5'd12;
        id_rs1      = 5'd12;
        id_rs1_used = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                checks++;
                if (stall_cycles !== 4'd14) begin errors++; $display("[TB] FAIL sat_mid: got %0d expected 14", stall_cycles); end
            end
        end
        #1;
        checks++;
        if (pc_en !== 1'b0) begin errors++; $display("[TB] FAIL sat_pc_en: got %b expected 0", pc_en); end
        checks++;
        if (stall_cycles !== 4'd15) begin errors++; $display("[TB] FAIL sat_value: got %0d expected 15", stall_cycles); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        RST = 1'b0;
        test_reset();
        test_load_use();
        test_vector();
        test_branch_priority();
        test_branch_during_vbusy();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
